// File: rtl/serial_link_pkg.sv
// Shared definitions for the one-bit serial link: field sizes, frame layout
// and the receiver FSM state encoding. Used by both sender and receiver.
package serial_link_pkg;

  localparam int DEF_SIZE_A = 7;
  localparam int DEF_SIZE_D = 8;

  // Frame: start + A + sep + D + sep + stop, MSB first.
  localparam int FRAME_BITS = 1 + DEF_SIZE_A + 1 + DEF_SIZE_D + 1 + 1;
  localparam int START_POS  = 0;
  localparam int SEP1_POS   = START_POS + DEF_SIZE_A + 1;
  localparam int SEP2_POS   = SEP1_POS + DEF_SIZE_D + 1;
  localparam int STOP_POS   = SEP2_POS + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SEP1,
    ST_DATA,
    ST_SEP2,
    ST_STOP
  } state_e;

endpackage

// File: rtl/serial_in_sync.sv
// Brings the asynchronous link clock and data into the clk_in domain and
// flags each rising edge of the link clock.
module serial_in_sync (
  input  logic clk_in,
  input  logic reset_n,
  input  logic c_i,
  input  logic d_i,
  output logic d_s2_o,
  output logic rise_o
);

  logic c_s1_q, c_s2_q, c_s3_q;
  logic d_s1_q, d_s2_q;

  // Flops reset to 1 (the idle line level) so releasing reset never fakes an edge.
  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      c_s3_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      c_s1_q <= c_i;
      c_s2_q <= c_s1_q;
      c_s3_q <= c_s2_q;
      d_s1_q <= d_i;
      d_s2_q <= d_s1_q;
    end
  end

  assign d_s2_o = d_s2_q;
  assign rise_o = c_s2_q & ~c_s3_q;

endmodule

// File: rtl/serial_in_receiver.sv
// Receive side of the serial link: oversamples InC/InD, rebuilds the address
// and data words of each frame and strobes Valid (good frame) or Err.
module serial_in_receiver
  import serial_link_pkg::*;
#(
  parameter int SIZE_A  = DEF_SIZE_A,
  parameter int SIZE_D  = DEF_SIZE_D,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              InD,
  input  logic              InC,
  output logic [SIZE_A-1:0] A_out,
  output logic [SIZE_D-1:0] D_out,
  output logic              Valid,
  output logic              Err,
  output logic              Busy
);

  // Frame positions scaled from the package layout to this instance's widths.
  localparam int DA          = SIZE_A - DEF_SIZE_A;
  localparam int DD          = SIZE_D - DEF_SIZE_D;
  localparam int CNT_W       = $clog2(FRAME_BITS + DA + DD);
  localparam int TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FIRST_A = CNT_W'(START_POS + 1);
  localparam logic [CNT_W-1:0] LAST_A  = CNT_W'(SEP1_POS - 1 + DA);
  localparam logic [CNT_W-1:0] LAST_D  = CNT_W'(SEP2_POS - 1 + DA + DD);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  logic d_s2, rise;

  serial_in_sync u_sync (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .c_i    (InC),
    .d_i    (InD),
    .d_s2_o (d_s2),
    .rise_o (rise)
  );

  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [SIZE_A-1:0] a_sr_q, a_out_q;
  logic [SIZE_D-1:0] d_sr_q, d_out_q;
  logic              valid_q, err_q;

  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      a_sr_q    <= '0;
      d_sr_q    <= '0;
      a_out_q   <= '0;
      d_out_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rise) begin
        // A rise always wins over a timeout expiring in the same cycle.
        to_cnt_q  <= '0;
        bit_cnt_q <= bit_cnt_q + 1'b1;
        unique case (state_q)
          ST_IDLE: begin
            bit_cnt_q <= bit_cnt_q;
            if (!d_s2) begin
              bit_cnt_q <= FIRST_A;
              state_q   <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            a_sr_q <= {a_sr_q[SIZE_A-2:0], d_s2};
            if (bit_cnt_q == LAST_A) state_q <= ST_SEP1;
          end
          ST_SEP1: state_q <= ST_DATA;
          ST_DATA: begin
            d_sr_q <= {d_sr_q[SIZE_D-2:0], d_s2};
            if (bit_cnt_q == LAST_D) state_q <= ST_SEP2;
          end
          ST_SEP2: state_q <= ST_STOP;
          ST_STOP: begin
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
            if (!d_s2) begin
              a_out_q <= a_sr_q;
              d_out_q <= d_sr_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          to_cnt_q  <= '0;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
          err_q     <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  assign A_out = a_out_q;
  assign D_out = d_out_q;
  assign Valid = valid_q;
  assign Err   = err_q;
  assign Busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_in_receiver.sv
// Bench for serial_in_receiver: drives whole frames at a 20 MHz link clock and
// compares each Valid/Err strobe against a frame-level reference model.
module tb_serial_in_receiver;

  localparam int TIMEOUT = 64;

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b1;
  logic       InD     = 1'b1;
  logic       InC     = 1'b1;
  logic [6:0] A_out;
  logic [7:0] D_out;
  logic       Valid, Err, Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: the words of the last frame whose stop bit was 0.
  logic [6:0] model_a = '0;
  logic [7:0] model_d = '0;

  typedef struct {
    int         cyc;
    logic       v;
    logic       e;
    logic [6:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t ev_q[$];

  serial_in_receiver #(.SIZE_A(7), .SIZE_D(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .InD    (InD),
    .InC    (InC),
    .A_out  (A_out),
    .D_out  (D_out),
    .Valid  (Valid),
    .Err    (Err),
    .Busy   (Busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;
  always @(negedge clk_in)
    if (Valid || Err) ev_q.push_back('{cyc, Valid, Err, A_out, D_out});

  function automatic logic [0:18] mk_frame(input logic [6:0] a, input logic [7:0] d,
                                           input logic s1, input logic s2, input logic stop);
    return {1'b0, a, s1, d, s2, stop};
  endfunction

  // Frames start 2 time units after a falling clk edge so every InC rise
  // lands 2 units after a rising edge: the edge pipeline is deterministic.
  task automatic align();
    @(negedge clk_in);
    #2;
  endtask

  // Sends the first n bits of f; last_rise is the cycle number of the last InC rise.
  task automatic send_bits(input logic [0:18] f, input int n, output int last_rise);
    last_rise = 0;
    for (int i = 0; i < n; i++) begin
      InD = f[i];
      InC = 1'b0;
      #25;
      InC = 1'b1;
      last_rise = cyc;
      #25;
    end
    InD = 1'b1;
  endtask

  task automatic pop_event(output bit found, output ev_t e);
    e = '{default: '0};
    found = 0;
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      found = 1;
    end
  endtask

  task automatic settle();
    repeat (6) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({A_out, D_out, Valid, Err, Busy} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_asserted: A=%h D=%h V=%b E=%b B=%b, expected all 0", A_out, D_out, Valid, Err, Busy);
    end
    #20 reset_n = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    n_checks++;
    if ({A_out, D_out, Valid, Err, Busy} !== 18'h0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_released: A=%h D=%h V=%b E=%b B=%b events=%0d, expected all 0 and no events",
               A_out, D_out, Valid, Err, Busy, ev_q.size());
    end
  endtask

  task automatic test_good_frame();
    int r; bit found; ev_t e;
    align();
    send_bits(mk_frame(7'h55, 8'hA3, 1'bx, 1'bx, 1'b0), 19, r);
    settle();
    model_a = 7'h55;
    model_d = 8'hA3;
    pop_event(found, e);
    n_checks++;
    if (!found || e.cyc != r + 3 || e.v !== 1'b1 || e.e !== 1'b0 || e.a !== model_a || e.d !== model_d) begin
      n_fail++;
      $display("FAIL good_frame: found=%0d cyc=%0d v=%b e=%b a=%h d=%h, expected cyc=%0d v=1 e=0 a=%h d=%h",
               found, e.cyc, e.v, e.e, e.a, e.d, r + 3, model_a, model_d);
    end
    n_checks++;
    if (ev_q.size() != 0 || Busy !== 1'b0 || A_out !== model_a || D_out !== model_d) begin
      n_fail++;
      $display("FAIL good_frame_after: extra_events=%0d B=%b A=%h D=%h, expected 0 0 %h %h",
               ev_q.size(), Busy, A_out, D_out, model_a, model_d);
    end
  endtask

  task automatic test_idle_clocking();
    int r;
    align();
    for (int i = 0; i < 10; i++) begin
      send_bits(19'h7FFFF, 1, r);
      repeat (2) @(negedge clk_in);
      n_checks++;
      if (Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_clock_busy[%0d]: Busy=%b, expected 0", i, Busy);
      end
    end
    settle();
    n_checks++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_clock_events: got %0d strobes, expected 0", ev_q.size());
      ev_q.delete();
    end
  endtask

  task automatic test_bad_stop();
    int r; bit found; ev_t e;
    align();
    send_bits(mk_frame(7'h7F, 8'h00, 1'bx, 1'bx, 1'b1), 19, r);
    settle();
    pop_event(found, e);
    n_checks++;
    if (!found || e.cyc != r + 3 || e.v !== 1'b0 || e.e !== 1'b1 || e.a !== 7'h55 || e.d !== 8'hA3) begin
      n_fail++;
      $display("FAIL bad_stop: found=%0d cyc=%0d v=%b e=%b a=%h d=%h, expected cyc=%0d v=0 e=1 a=55 d=a3",
               found, e.cyc, e.v, e.e, e.a, e.d, r + 3);
    end
    n_checks++;
    if (ev_q.size() != 0 || A_out !== 7'h55 || D_out !== 8'hA3) begin
      n_fail++;
      $display("FAIL bad_stop_hold: extra_events=%0d A=%h D=%h, expected 0 55 a3", ev_q.size(), A_out, D_out);
    end
  endtask

  task automatic test_random_frames();
    int r; bit found; ev_t e;
    logic [6:0] a; logic [7:0] d; logic stop;
    for (int i = 0; i < 8; i++) begin
      a    = 7'($urandom);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) == 0);
      align();
      send_bits(mk_frame(a, d, 1'($urandom), 1'($urandom), stop), 19, r);
      settle();
      if (!stop) begin
        model_a = a;
        model_d = d;
      end
      pop_event(found, e);
      n_checks++;
      if (!found || e.cyc != r + 3 || e.v !== !stop || e.e !== stop || e.a !== model_a || e.d !== model_d
          || ev_q.size() != 0) begin
        n_fail++;
        $display("FAIL random_frame[%0d]: found=%0d cyc=%0d v=%b e=%b a=%h d=%h extra=%0d, expected cyc=%0d v=%b e=%b a=%h d=%h extra=0",
                 i, found, e.cyc, e.v, e.e, e.a, e.d, ev_q.size(), r + 3, !stop, stop, model_a, model_d);
        ev_q.delete();
      end
    end
  endtask

  task automatic test_timeout();
    int r; bit found; ev_t e;
    logic [6:0] a; logic [7:0] d;
    align();
    send_bits(mk_frame(7'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0), 10, r);
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_busy_mid: Busy=%b, expected 1", Busy);
    end
    repeat (TIMEOUT + 8) @(posedge clk_in);
    #1;
    pop_event(found, e);
    n_checks++;
    if (!found || e.cyc != r + 3 + TIMEOUT || e.v !== 1'b0 || e.e !== 1'b1 || e.a !== model_a || e.d !== model_d) begin
      n_fail++;
      $display("FAIL timeout_err: found=%0d cyc=%0d v=%b e=%b a=%h d=%h, expected cyc=%0d v=0 e=1 a=%h d=%h",
               found, e.cyc, e.v, e.e, e.a, e.d, r + 3 + TIMEOUT, model_a, model_d);
    end
    n_checks++;
    if (Busy !== 1'b0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_idle: Busy=%b extra_events=%0d, expected 0 0", Busy, ev_q.size());
      ev_q.delete();
    end
    a = 7'($urandom);
    d = 8'($urandom);
    align();
    send_bits(mk_frame(a, d, 1'b1, 1'b0, 1'b0), 19, r);
    settle();
    model_a = a;
    model_d = d;
    pop_event(found, e);
    n_checks++;
    if (!found || e.cyc != r + 3 || e.v !== 1'b1 || e.a !== model_a || e.d !== model_d) begin
      n_fail++;
      $display("FAIL timeout_recover: found=%0d cyc=%0d v=%b a=%h d=%h, expected cyc=%0d v=1 a=%h d=%h",
               found, e.cyc, e.v, e.a, e.d, r + 3, model_a, model_d);
    end
  endtask

  task automatic test_back_to_back();
    int r, r1, r2; bit found; ev_t e;
    align();
    send_bits(mk_frame(7'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0), 13, r);
    reset_n = 1'b1;
    #1;
    model_a = '0;
    model_d = '0;
    n_checks++;
    if ({A_out, D_out, Valid, Err, Busy} !== 18'h0) begin
      n_fail++;
      $display("FAIL midframe_reset: A=%h D=%h V=%b E=%b B=%b, expected all 0", A_out, D_out, Valid, Err, Busy);
    end
    #30 reset_n = 1'b0;
    align();
    send_bits(mk_frame(7'h01, 8'hFF, 1'bx, 1'bx, 1'b0), 19, r1);
    send_bits(mk_frame(7'h40, 8'h80, 1'bx, 1'bx, 1'b0), 19, r2);
    settle();
    pop_event(found, e);
    n_checks++;
    if (!found || e.cyc != r1 + 3 || e.v !== 1'b1 || e.a !== 7'h01 || e.d !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_first: found=%0d cyc=%0d v=%b a=%h d=%h, expected cyc=%0d v=1 a=01 d=ff",
               found, e.cyc, e.v, e.a, e.d, r1 + 3);
    end
    pop_event(found, e);
    n_checks++;
    if (!found || e.cyc != r2 + 3 || e.v !== 1'b1 || e.a !== 7'h40 || e.d !== 8'h80) begin
      n_fail++;
      $display("FAIL b2b_second: found=%0d cyc=%0d v=%b a=%h d=%h, expected cyc=%0d v=1 a=40 d=80",
               found, e.cyc, e.v, e.a, e.d, r2 + 3);
    end
    n_checks++;
    if (ev_q.size() != 0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_after: extra_events=%0d Busy=%b, expected 0 0", ev_q.size(), Busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_idle_clocking();
    test_bad_stop();
    test_random_frames();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
